// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared types and constants for the HI/LO multiply/divide controller:
//   - md_op_e  : op select driven by the main decoder (MULT/MULTU/DIV/DIVU)
//   - state_e  : controller FSM states
//   - helpers  : op classification and two's-complement magnitude
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   // Last divide iteration: 32 quotient bits, counter runs 0..31.
   localparam logic [CNT_W-1:0] DIV_LAST = 6'd31;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic is_div_op(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_signed_op(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   // Magnitude of v when treated as signed (sgn=1), else v unchanged.
   // -32'h8000_0000 wraps to itself, which is the correct unsigned magnitude.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_if
// EX-stage <-> multiply/divide controller connection.
//   master (EX / decoder side): drives start, md_op, opa, opb, flush
//   slave  (muldiv_ctrl)      : drives stall_o, result_valid, hi_o, lo_o
// ---------------------------------------------------------------------------
interface muldiv_ctrl_if;
   import muldiv_ctrl_pkg::*;

   logic            start;         // valid mul/div instruction in EX
   logic [1:0]      md_op;         // MULT, MULTU, DIV, DIVU
   logic [XLEN-1:0] opa;           // rs: multiplicand / dividend
   logic [XLEN-1:0] opb;           // rt: multiplier / divisor
   logic            flush;         // pipeline kill
   logic            stall_o;       // freeze IF..EX
   logic            result_valid;  // one-cycle HI/LO write strobe
   logic [XLEN-1:0] hi_o;          // product high / remainder
   logic [XLEN-1:0] lo_o;          // product low / quotient

   modport master (
      output start, md_op, opa, opb, flush,
      input  stall_o, result_valid, hi_o, lo_o
   );

   modport slave (
      input  start, md_op, opa, opb, flush,
      output stall_o, result_valid, hi_o, lo_o
   );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Restoring shift-subtract divider step register (unsigned magnitudes).
// A 64-bit accumulator holds {partial remainder, dividend/quotient bits}.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   load                : capture dividend/divisor, clear partial remainder
//   step                : advance one quotient bit
//   dividend, divisor   : unsigned operands sampled on load
//   quotient, remainder : accumulator contents AFTER the step taken in the
//                         current cycle, so the controller can latch the
//                         final result on the same edge as the 32nd step
// ---------------------------------------------------------------------------
module div_iter
   import muldiv_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [2*XLEN-1:0] acc_q, acc_next;
   logic [XLEN-1:0]   dvs_q;
   logic [XLEN:0]     rem_sh;   // partial remainder shifted left, next dividend bit in
   logic              fits;

   always_comb begin
      rem_sh = acc_q[2*XLEN-1:XLEN-1];
      fits   = (rem_sh >= {1'b0, dvs_q});
      // When the divisor fits the true difference is < divisor, so the low
      // XLEN bits of the subtraction are exact.
      if (fits) begin
         acc_next = {rem_sh[XLEN-1:0] - dvs_q, acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {acc_q[2*XLEN-2:0], 1'b0};
      end
   end

   assign quotient  = acc_next[XLEN-1:0];
   assign remainder = acc_next[2*XLEN-1:XLEN];

   // NOTE: wide datapath registers are reset here only because the result
   // path must read as zero after reset; true storage arrays are left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         acc_q <= {{XLEN{1'b0}}, dividend};
         dvs_q <= divisor;
      end else if (step) begin
         acc_q <= acc_next;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle HI/LO multiply/divide controller for the 5-stage MIPS EX stage.
// Accepts MULT/MULTU/DIV/DIVU from IDLE, stalls the pipeline while busy and
// pulses result_valid for one cycle when hi_o/lo_o hold the new result.
// Ports:
//   clk, rst : core clock, asynchronous active-high reset
//   md       : muldiv_ctrl_if.slave (start, md_op, opa, opb, flush in;
//              stall_o, result_valid, hi_o, lo_o out)
// Parameters:
//   MUL_LAT  : cycles spent in MUL before DONE (>= 1, < 64)
//   WIDTH    : operand width (only 32 supported)
// Build option:
//   MULDIV_EARLY_EXIT_EN : divides with |dividend| < |divisor| skip the
//                          iterations (same results, shorter stall)
// ---------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 2,
   parameter int WIDTH   = 32
)
(
   input  logic          clk,
   input  logic          rst,
   muldiv_ctrl_if.slave  md
);

   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

   state_e            state, state_next;
   md_op_e            op_in;
   logic              accept, in_div, in_signed, div_zero, early_exit;
   logic              res_load, div_step;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [2*XLEN-1:0] product_d, product_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              signed_q, sign_a_q, sign_b_q;
   logic [XLEN-1:0]   div_quo, div_rem, quo_fix, rem_fix;
   logic [WIDTH-1:0]  hi_q, lo_q, hi_d, lo_d;

   // ---------------- request decode ----------------
   assign op_in     = md_op_e'(md.md_op);
   assign in_div    = is_div_op(op_in);
   assign in_signed = is_signed_op(op_in);
   assign accept    = (state == IDLE) && md.start && !md.flush;
   assign abs_a     = magnitude(md.opa, in_signed);
   assign abs_b     = magnitude(md.opb, in_signed);
   assign div_zero  = (md.opb == '0);

`ifdef MULDIV_EARLY_EXIT_EN
   // Quotient is 0 and remainder is opa itself: nothing to iterate.
   assign early_exit = (abs_a < abs_b);
`else
   assign early_exit = 1'b0;
`endif

   // Sign-extend for signed ops; the low 64 bits of a 64x64 product are the
   // correct signed or unsigned 32x32 product.
   assign product_d = {{XLEN{in_signed & md.opa[XLEN-1]}}, md.opa} *
                      {{XLEN{in_signed & md.opb[XLEN-1]}}, md.opb};

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!in_div)                     state_next = MUL;
               else if (div_zero || early_exit) state_next = DONE;
               else                             state_next = DIV;
            end
         end
         MUL:     if (cnt_q == MUL_LAST) state_next = DONE;
         DIV:     if (cnt_q == DIV_LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // Flush kills the operation (and any same-cycle start) in every state.
      if (md.flush) state_next = IDLE;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      md.stall_o      = !rst && (accept || (state == MUL) || (state == DIV));
      md.result_valid = (state == DONE) && !md.flush;
      div_step        = (state == DIV);
   end

   // ---------------- divider ----------------
   div_iter u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (accept && in_div),
      .step      (div_step),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Quotient negative when operand signs differ; remainder follows dividend.
   assign quo_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? -div_quo : div_quo;
   assign rem_fix = (signed_q && sign_a_q)              ? -div_rem : div_rem;

   // ---------------- result select ----------------
   // Loaded only on entry to DONE; flushed paths never reach DONE.
   assign res_load = (state_next == DONE) && (state != DONE);

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      case (state)
         IDLE: begin
            // Direct IDLE->DONE divides: divide-by-zero or early exit.
            hi_d = md.opa;
            lo_d = div_zero ? '1 : '0;
         end
         MUL:     {hi_d, lo_d} = product_q;
         DIV: begin
            hi_d = rem_fix;
            lo_d = quo_fix;
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         product_q <= '0;
         signed_q  <= 1'b0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         if (accept) begin
            cnt_q    <= '0;
            signed_q <= in_signed;
            sign_a_q <= md.opa[XLEN-1];
            sign_b_q <= md.opb[XLEN-1];
            if (!in_div) product_q <= product_d;
         end else if ((state == MUL) || (state == DIV)) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (res_load) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
         end
      end
   end

   assign md.hi_o = hi_q;
   assign md.lo_o = lo_q;

endmodule
